// File: rtl/alu_operand_sequencer.sv
// Operand sequencer for the Tiny Tapeout ALU: loads A, B and the op select from one
// shared 8-bit bus on successive host strobes, then latches the ALU result and pulses done.
module alu_operand_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] data_in,
  input  logic       load,
  input  logic       clear,
  input  logic [7:0] result_in,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [1:0] sel,
  output logic [7:0] result_q,
  output logic       done,
  output logic [2:0] state,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] load_sync_q, load_sync_d;
  logic [SYNC_STAGES-1:0] clear_sync_q, clear_sync_d;
  logic                   load_prev_q, load_prev_d;
  logic [7:0]             a_q, a_d;
  logic [7:0]             b_q, b_d;
  logic [1:0]             sel_q, sel_d;
  logic [7:0]             res_q, res_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   load_s;
  logic                   clear_s;
  logic                   load_rise;

  assign load_s    = load_sync_q[SYNC_STAGES-1];
  assign clear_s   = clear_sync_q[SYNC_STAGES-1];
  assign load_rise = load_s & ~load_prev_q;

  // Synchronizer shift chains keep running even while ena is low.
  always_comb begin
    load_sync_d  = {load_sync_q[SYNC_STAGES-2:0], load};
    clear_sync_d = {clear_sync_q[SYNC_STAGES-2:0], clear};
  end

  // Next-state, field capture and output pulse generation.
  always_comb begin
    state_d     = state_q;
    load_prev_d = load_prev_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    res_d       = res_q;
    done_d      = 1'b0;
    if (ena) begin
      load_prev_d = load_s;
      if (clear_s) begin
        // Abort only rewinds the sequence; captured fields stay visible.
        state_d = ST_WAIT_A;
      end else begin
        case (state_q)
          ST_WAIT_A: begin
            if (load_rise) begin
              a_d     = data_in;
              state_d = ST_WAIT_B;
            end else begin
              state_d = ST_WAIT_A;
            end
          end
          ST_WAIT_B: begin
            if (load_rise) begin
              b_d     = data_in;
              state_d = ST_WAIT_OP;
            end else begin
              state_d = ST_WAIT_B;
            end
          end
          ST_WAIT_OP: begin
            if (load_rise) begin
              sel_d   = data_in[1:0];
              state_d = ST_EXEC;
            end else begin
              state_d = ST_WAIT_OP;
            end
          end
          ST_EXEC: begin
            res_d   = result_in;
            state_d = ST_DONE;
          end
          ST_DONE: state_d = ST_WAIT_A;
          default: state_d = ST_WAIT_A;
        endcase
      end
      done_d = (state_d == ST_DONE) ? 1'b1 : 1'b0;
    end else begin
      done_d = 1'b0;
    end
    busy_d = ((state_d == ST_EXEC) || (state_d == ST_DONE)) ? 1'b1 : 1'b0;
  end

  // Synchronizer flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_sync_q  <= '0;
      clear_sync_q <= '0;
    end else begin
      load_sync_q  <= load_sync_d;
      clear_sync_q <= clear_sync_d;
    end
  end

  // FSM, field and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT_A;
      load_prev_q <= 1'b0;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      sel_q       <= 2'b00;
      res_q       <= 8'h00;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_prev_q <= load_prev_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      res_q       <= res_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign sel      = sel_q;
  assign result_q = res_q;
  assign done     = done_q;
  assign state    = state_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: directed test-plan cases with literal expectations,
// then random strobes/aborts/enable gaps checked every cycle against a step-level model.
module tb_alu_operand_sequencer;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] data_in;
  logic       load;
  logic       clear;
  logic [7:0] result_in;
  logic [7:0] a, b, result_q;
  logic [1:0] sel;
  logic       done, busy;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  alu_operand_sequencer #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .load(load),
    .clear(clear), .result_in(result_in), .a(a), .b(b), .sel(sel),
    .result_q(result_q), .done(done), .state(state), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_alu(input logic [7:0] x, input logic [7:0] y,
                                         input logic [1:0] op);
    case (op)
      2'b00:   return x + y;
      2'b01:   return x - y;
      2'b10:   return x & y;
      default: return x | y;
    endcase
  endfunction

  // Combinational ALU sitting downstream of the sequencer.
  always_comb result_in = ref_alu(a, b, sel);

  // Reference model: a delay line stands in for the synchronizers; m_step counts
  // which field the host is on (0..2), then execute (3) and report (4).
  logic [3:0] m_lh, m_ch;
  logic       m_prev;
  int         m_step;
  logic [7:0] m_f [3];
  logic [7:0] m_res;
  logic       m_done;
  logic       m_ls, m_cs, m_rise;

  assign m_ls   = m_lh[SYNC-1];
  assign m_cs   = m_ch[SYNC-1];
  assign m_rise = m_ls && !m_prev;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lh <= 4'h0; m_ch <= 4'h0; m_prev <= 1'b0; m_step <= 0;
      m_f[0] <= 8'h00; m_f[1] <= 8'h00; m_f[2] <= 8'h00;
      m_res <= 8'h00; m_done <= 1'b0;
    end else begin
      m_lh   <= {m_lh[2:0], load};
      m_ch   <= {m_ch[2:0], clear};
      m_done <= 1'b0;
      if (ena) begin
        m_prev <= m_ls;
        if (m_cs) m_step <= 0;
        else if (m_step <= 2) begin
          if (m_rise) begin
            m_f[m_step] <= (m_step == 2) ? {6'd0, data_in[1:0]} : data_in;
            m_step      <= m_step + 1;
          end
        end else if (m_step == 3) begin
          m_res  <= ref_alu(m_f[0], m_f[1], m_f[2][1:0]);
          m_step <= 4;
          m_done <= 1'b1;
        end else m_step <= 0;
      end
    end
  end

  // One cycle: wait for the falling edge and compare every output against the model.
  task automatic tick();
    logic [30:0] got, exp;
    logic [2:0]  es;
    @(negedge clk);
    es  = 3'(m_step);
    exp = {m_f[0], m_f[1], m_f[2][1:0], m_res, m_done, es, (m_step == 3 || m_step == 4)};
    got = {a, b, sel, result_q, done, state, busy};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL cycle_model t=%0t got a=%h b=%h sel=%h res=%h done=%b st=%0d busy=%b want a=%h b=%h sel=%h res=%h done=%b st=%0d busy=%b",
               $time, a, b, sel, result_q, done, state, busy,
               m_f[0], m_f[1], m_f[2][1:0], m_res, m_done, es, exp[0]);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] v);
    data_in = v;
    load = 1'b1;
    repeat (SYNC + 1) tick();
    load = 1'b0;
    repeat (SYNC + 1) tick();
  endtask

  // Op strobe with the result timing pinned literally.
  task automatic strobe_op(input string name, input logic [7:0] v, input logic [7:0] r);
    data_in = v;
    load = 1'b1;
    repeat (SYNC + 1) tick();
    check({name, "_exec_state"}, 32'(state), 32'd3);
    check({name, "_exec_done"}, 32'(done), 32'd0);
    load = 1'b0;
    tick();
    check({name, "_done_pulse"}, 32'(done), 32'd1);
    check({name, "_result"}, 32'(result_q), 32'(r));
    tick();
    check({name, "_done_low"}, 32'(done), 32'd0);
    check({name, "_back_idle"}, 32'(state), 32'd0);
    repeat (SYNC - 1) tick();
  endtask

  task automatic rtick();
    ena = ($urandom_range(0, 5) != 0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; data_in = 8'h00; load = 1'b0; clear = 1'b0;
    repeat (3) tick();
    check("rst_a", 32'(a), 32'h00);
    check("rst_state", 32'(state), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    strobe(8'h05); strobe(8'h03);
    strobe_op("add", 8'h00, 8'h08);
    check("add_a", 32'(a), 32'h05);
    check("add_b", 32'(b), 32'h03);
    check("add_sel", 32'(sel), 32'd0);

    strobe(8'h03); strobe(8'h05);
    strobe_op("sub", 8'h01, 8'hFE);

    strobe(8'hFF); strobe(8'h02);
    strobe_op("ovf", 8'hFC, 8'h01);
    check("ovf_sel", 32'(sel), 32'd0);

    strobe(8'h11); strobe(8'h22);
    clear = 1'b1;
    repeat (SYNC + 3) tick();
    check("abort_state", 32'(state), 32'd0);
    check("abort_a", 32'(a), 32'h11);
    check("abort_b", 32'(b), 32'h22);
    clear = 1'b0;
    repeat (SYNC + 1) tick();
    strobe(8'h0F); strobe(8'hF0);
    strobe_op("and", 8'h02, 8'h00);

    // Second rise arrives while the result is being reported and must be dropped.
    strobe(8'h21); strobe(8'h43);
    data_in = 8'h03;
    load = 1'b1; tick();
    load = 1'b0; tick();
    load = 1'b1; repeat (SYNC + 1) tick();
    load = 1'b0; repeat (SYNC + 1) tick();
    check("drop_state", 32'(state), 32'd0);
    check("drop_a", 32'(a), 32'h21);
    check("drop_res", 32'(result_q), 32'h63);

    strobe(8'h5A);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ena_state", 32'(state), 32'd1);
      check("ena_a", 32'(a), 32'h5A);
      check("ena_done", 32'(done), 32'd0);
    end
    ena = 1'b1;

    strobe(8'h77);
    data_in = 8'hAA; load = 1'b1; tick();
    rst_n = 1'b0; load = 1'b0;
    tick();
    check("midrst_a", 32'(a), 32'h00);
    check("midrst_b", 32'(b), 32'h00);
    check("midrst_res", 32'(result_q), 32'h00);
    check("midrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    check("midrst_state", 32'(state), 32'd0);
    repeat (SYNC + 1) tick();

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        clear = 1'b1;
        repeat ($urandom_range(1, 4)) rtick();
        clear = 1'b0;
        repeat (SYNC + 1) rtick();
      end else begin
        data_in = 8'($urandom);
        load = 1'b1;
        repeat ($urandom_range(SYNC + 1, SYNC + 3)) rtick();
        load = 1'b0;
        repeat ($urandom_range(SYNC + 1, SYNC + 3)) rtick();
      end
    end
    ena = 1'b1;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
